// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
package icache_pkg;

  // cpu_size encodings; 2'b11 is served as a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Widest line the extraction helper can take (128 bytes).
  localparam int MAX_LINE_BITS = 1024;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  // Pick the addressed word out of a line, then narrow it to the access size.
  function automatic logic [31:0] load_from_line(
    input logic [MAX_LINE_BITS-1:0] line,
    input logic [7:0]               word_off,
    input logic [1:0]               size,
    input logic [1:0]               byte_off
  );
    logic [31:0] word;
    word = line[32*int'(word_off) +: 32];
    case (size)
      SIZE_BYTE: load_from_line = {24'h0, word[8*int'(byte_off) +: 8]};
      SIZE_HALF: load_from_line = byte_off[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      default:   load_from_line = word;
    endcase
  endfunction

endpackage

// File: rtl/instr_cache_assoc_if.sv
// Fetch-side and memory-side bus of the instruction cache.
//
// Handshakes:
//   CPU:    a request is taken on the rising edge where cpu_req && cpu_ready;
//           the answer is a single-cycle cpu_rvalid pulse (no backpressure).
//   Memory: mem_req is held with a stable mem_addr until the edge where
//           mem_gnt is high; the whole line arrives once with mem_rvalid,
//           which may coincide with mem_gnt.
interface instr_cache_assoc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
);
  logic                    cpu_req;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [1:0]              cpu_size;
  logic                    cpu_ready;
  logic [31:0]             cpu_rdata;
  logic                    cpu_rvalid;
  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [LINE_BYTES*8-1:0] mem_rdata;

  // Cache side.
  modport slave (
    input  cpu_req, cpu_addr, cpu_size, mem_gnt, mem_rvalid, mem_rdata,
    output cpu_ready, cpu_rdata, cpu_rvalid, mem_req, mem_addr
  );

  // CPU + arbiter side.
  modport master (
    output cpu_req, cpu_addr, cpu_size, mem_gnt, mem_rvalid, mem_rdata,
    input  cpu_ready, cpu_rdata, cpu_rvalid, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_victim_sel.sv
// Victim choice for one set: lowest-index invalid way, else the round-robin pointer.
module icache_victim_sel #(
  parameter int N_WAYS   = 2,
  parameter int WAY_BITS = 1
) (
  input  logic [N_WAYS-1:0]   valid_i,
  input  logic [WAY_BITS-1:0] rr_ptr_i,
  output logic [WAY_BITS-1:0] victim_o,
  output logic                used_ptr_o
);
  // Scan downward so the last hit written is the lowest invalid way.
  always_comb begin
    victim_o   = rr_ptr_i;
    used_ptr_o = 1'b1;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o   = WAY_BITS'(w);
        used_ptr_o = 1'b0;
      end
    end
  end
endmodule

// File: rtl/instr_cache_assoc.sv
// N-way set-associative read-only instruction cache.
// Optional feature macro: ICACHE_PERF_CNT_EN (live hit/miss counters; tied to 0 otherwise).
module instr_cache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int N_SETS     = 4,
  parameter int N_WAYS     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  instr_cache_assoc_if.slave  bus,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output state_t              state_o
);
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int IDX_BITS    = $clog2(N_SETS);
  localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - IDX_BITS;
  localparam int WAY_BITS    = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int LINE_BITS   = LINE_BYTES * 8;

  state_t state_q, state_d;

  logic [N_WAYS-1:0]   valid_q  [N_SETS];
  logic [TAG_BITS-1:0] tag_q    [N_SETS][N_WAYS];
  logic [LINE_BITS-1:0] data_q  [N_SETS][N_WAYS];
  logic [WAY_BITS-1:0] rr_ptr_q [N_SETS];

  // Miss context captured at acceptance.
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [1:0]            req_size_q;
  logic [WAY_BITS-1:0]   victim_q;
  logic                  used_ptr_q;
  logic                  flush_pend_q;

  logic                  cpu_ready_q, cpu_ready_d;
  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic [31:0]           cpu_rdata_q, cpu_rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [IDX_BITS-1:0]   lk_set, r_set;
  logic [TAG_BITS-1:0]   lk_tag, r_tag;
  logic [N_WAYS-1:0]     hit_vec;
  logic [WAY_BITS-1:0]   hit_way, victim;
  logic                  used_ptr, lookup_hit;
  logic                  accept, accept_hit, accept_miss, fill_done, drop_fill, install;
  logic [MAX_LINE_BITS-1:0] line_ext;

  assign lk_set = bus.cpu_addr[OFFSET_BITS +: IDX_BITS];
  assign lk_tag = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign r_set  = req_addr_q[OFFSET_BITS +: IDX_BITS];
  assign r_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_BITS];

  // Parallel tag compare across every way of the addressed set.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      hit_vec[w] = valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag);
      if (hit_vec[w]) hit_way = WAY_BITS'(w);
    end
  end
  assign lookup_hit = |hit_vec;

  icache_victim_sel #(.N_WAYS(N_WAYS), .WAY_BITS(WAY_BITS)) u_victim_sel (
    .valid_i    (valid_q[lk_set]),
    .rr_ptr_i   (rr_ptr_q[lk_set]),
    .victim_o   (victim),
    .used_ptr_o (used_ptr)
  );

  // A request arriving together with flush is refused in that same cycle.
  assign accept      = (state_q == S_IDLE) && bus.cpu_req && cpu_ready_q && !flush;
  assign accept_hit  = accept && lookup_hit;
  assign accept_miss = accept && !lookup_hit;
  assign fill_done   = (state_q == S_REFILL) && bus.mem_rvalid;
  assign drop_fill   = flush_pend_q || flush;
  assign install     = fill_done && !drop_fill;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_miss) state_d = S_REFILL;
      S_REFILL: if (bus.mem_rvalid) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered bus outputs.
  always_comb begin
    cpu_ready_d  = cpu_ready_q;
    cpu_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    line_ext     = '0;
    case (state_q)
      S_IDLE: begin
        if (accept_hit) begin
          line_ext[LINE_BITS-1:0] = data_q[lk_set][hit_way];
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = load_from_line(line_ext, 8'(bus.cpu_addr[OFFSET_BITS-1:0] >> 2),
                                        bus.cpu_size, bus.cpu_addr[1:0]);
        end else if (accept_miss) begin
          cpu_ready_d = 1'b0;
          mem_req_d   = 1'b1;
          mem_addr_d  = {bus.cpu_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        end
      end
      S_REFILL: begin
        if (bus.mem_gnt) mem_req_d = 1'b0;
        if (bus.mem_rvalid) begin
          line_ext[LINE_BITS-1:0] = bus.mem_rdata;
          mem_req_d    = 1'b0;
          cpu_ready_d  = 1'b1;
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = load_from_line(line_ext, 8'(req_addr_q[OFFSET_BITS-1:0] >> 2),
                                        req_size_q, req_addr_q[1:0]);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, valid bits, victim pointers and miss context; reset abandons a fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ready_q  <= 1'b1;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      req_addr_q   <= '0;
      req_size_q   <= '0;
      victim_q     <= '0;
      used_ptr_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < N_SETS; s++) begin
        valid_q[s]  <= '0;
        rr_ptr_q[s] <= '0;
      end
    end else begin
      cpu_ready_q  <= cpu_ready_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      if (accept_miss) begin
        req_addr_q <= bus.cpu_addr;
        req_size_q <= bus.cpu_size;
        victim_q   <= victim;
        used_ptr_q <= used_ptr;
      end
      if (state_q == S_IDLE && flush) begin
        for (int s = 0; s < N_SETS; s++) valid_q[s] <= '0;
      end else if (fill_done) begin
        flush_pend_q <= 1'b0;
        if (drop_fill) begin
          for (int s = 0; s < N_SETS; s++) valid_q[s] <= '0;
        end else begin
          valid_q[r_set][victim_q] <= 1'b1;
          if (used_ptr_q)
            rr_ptr_q[r_set] <= (int'(victim_q) == N_WAYS - 1) ? '0 : victim_q + 1'b1;
        end
      end else if (state_q == S_REFILL && flush) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[r_set][victim_q]  <= r_tag;
      data_q[r_set][victim_q] <= bus.mem_rdata;
    end
  end

  assign bus.cpu_ready  = cpu_ready_q & ~flush;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign state_o        = state_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters on accepted lookups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept_hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (accept_miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  // A tag must never be resident in two ways of one set.
  assert property (@(posedge clk) disable iff (rst) $onehot0(hit_vec));

endmodule
